// File: rtl/sigma_mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter for one shared memory port; one access in flight at a time.
// Define SIGMA_ARB_ROUND_ROBIN_EN for alternating grants; default build is fixed CPU priority.
module sigma_mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_gnt,
    output logic        cpu_rvalid,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_gnt,
    output logic        dma_rvalid,
    output logic [31:0] dma_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    typedef enum logic [1:0] {IDLE, CPU_XFER, DMA_XFER} state_t;

    state_t state_q, state_d;
    logic   pick_dma;

`ifdef SIGMA_ARB_ROUND_ROBIN_EN
    logic rr_dma_next;

    // Pointer names the requester that wins the next tie; starts at CPU.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_dma_next <= 1'b0;
        end else if (cpu_gnt) begin
            rr_dma_next <= 1'b1;
        end else if (dma_gnt) begin
            rr_dma_next <= 1'b0;
        end
    end

    always_comb begin
        pick_dma = dma_req && (!cpu_req || rr_dma_next);
    end
`else
    always_comb begin
        pick_dma = dma_req && !cpu_req;
    end
`endif

    // Next state and combinational grants (grants only in IDLE, never during reset).
    always_comb begin
        state_d = state_q;
        cpu_gnt = 1'b0;
        dma_gnt = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset) begin
                    if (pick_dma) begin
                        dma_gnt = 1'b1;
                        state_d = DMA_XFER;
                    end else if (cpu_req) begin
                        cpu_gnt = 1'b1;
                        state_d = CPU_XFER;
                    end
                end
            end
            CPU_XFER, DMA_XFER: begin
                if (mem_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory command capture, completion pulses and read-data return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
            dma_rvalid <= 1'b0;
            dma_rdata  <= '0;
            busy       <= 1'b0;
            owner      <= 1'b0;
        end else begin
            cpu_rvalid <= 1'b0;
            dma_rvalid <= 1'b0;
            busy       <= (state_d != IDLE);
            if (cpu_gnt) begin
                mem_req   <= 1'b1;
                mem_we    <= cpu_we;
                mem_addr  <= AW'(cpu_addr);
                mem_wdata <= DW'(cpu_wdata);
                owner     <= 1'b0;
            end else if (dma_gnt) begin
                mem_req   <= 1'b1;
                mem_we    <= dma_we;
                mem_addr  <= AW'(dma_addr);
                mem_wdata <= DW'(dma_wdata);
                owner     <= 1'b1;
            end else if ((state_q != IDLE) && mem_ready) begin
                mem_req   <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= '0;
                mem_wdata <= '0;
                // Writes still complete with a pulse but return zero data.
                if (state_q == CPU_XFER) begin
                    cpu_rvalid <= 1'b1;
                    cpu_rdata  <= mem_we ? '0 : DW'(mem_rdata);
                end else begin
                    dma_rvalid <= 1'b1;
                    dma_rdata  <= mem_we ? '0 : DW'(mem_rdata);
                end
            end
        end
    end

endmodule

// File: tb/tb_sigma_mem_arbiter.sv
// Directed bench for sigma_mem_arbiter; expectations follow SIGMA_ARB_ROUND_ROBIN_EN if defined.
module tb_sigma_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        mem_req, mem_we, mem_ready, busy, owner;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    always #5 clk = ~clk;

    sigma_mem_arbiter dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) next_cycle();
        @(negedge clk);
        chk_cnt++;
        if ({cpu_gnt, dma_gnt, mem_req, mem_we, busy, owner} !== 6'b0)
            $display("FAIL reset_ctrl got %b want 000000", {cpu_gnt, dma_gnt, mem_req, mem_we, busy, owner});
        else pass_cnt++;
        chk_cnt++;
        if ({mem_addr, mem_wdata, cpu_rdata, dma_rdata, cpu_rvalid, dma_rvalid} !== 130'b0)
            $display("FAIL reset_data got nonzero addr=%h rdata=%h/%h", mem_addr, cpu_rdata, dma_rdata);
        else pass_cnt++;
        next_cycle();
        cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_cpu_read();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk_cnt++;
        if ({cpu_gnt, dma_gnt} !== 2'b10) $display("FAIL rd_gnt got %b want 10", {cpu_gnt, dma_gnt});
        else pass_cnt++;
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({mem_req, mem_we, busy, owner, cpu_gnt} !== 5'b10100 || mem_addr !== 32'h100)
            $display("FAIL rd_mem got req/we/busy/own/gnt=%b addr=%h want 10100 100",
                     {mem_req, mem_we, busy, owner, cpu_gnt}, mem_addr);
        else pass_cnt++;
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEAD_BEEF || mem_req !== 1'b0 || dma_rvalid !== 1'b0)
            $display("FAIL rd_done got rvalid=%b rdata=%h mem_req=%b want 1 deadbeef 0",
                     cpu_rvalid, cpu_rdata, mem_req);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if (cpu_rvalid !== 1'b0 || busy !== 1'b0) $display("FAIL rd_pulse got rvalid=%b busy=%b want 0 0", cpu_rvalid, busy);
        else pass_cnt++;
    endtask

    task automatic test_dma_write();
        next_cycle();
        dma_req = 1'b1; dma_we = 1'b1; dma_addr = 32'h40; dma_wdata = 32'h1234;
        mem_ready = 1'b0; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk_cnt++;
        if ({cpu_gnt, dma_gnt} !== 2'b01) $display("FAIL wr_gnt got %b want 01", {cpu_gnt, dma_gnt});
        else pass_cnt++;
        next_cycle();
        dma_req = 1'b0; dma_addr = 32'hFFFF; dma_wdata = 32'hFFFF;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            @(negedge clk);
            chk_cnt++;
            if ({mem_req, mem_we, dma_rvalid, owner, busy} !== 5'b11011 || mem_addr !== 32'h40 || mem_wdata !== 32'h1234)
                $display("FAIL wr_hold%0d got req/we/rv/own/busy=%b addr=%h wdata=%h want 11011 40 1234",
                         i, {mem_req, mem_we, dma_rvalid, owner, busy}, mem_addr, mem_wdata);
            else pass_cnt++;
            next_cycle();
        end
        mem_ready = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h0 || cpu_rdata !== 32'hDEAD_BEEF || mem_req !== 1'b0)
            $display("FAIL wr_done got rvalid=%b rdata=%h cpu_rdata=%h mem_req=%b want 1 0 deadbeef 0",
                     dma_rvalid, dma_rdata, cpu_rdata, mem_req);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if (dma_rvalid !== 1'b0) $display("FAIL wr_pulse got %b want 0", dma_rvalid);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic exp_dma [0:3];
        int   k;
`ifdef SIGMA_ARB_ROUND_ROBIN_EN
        exp_dma = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_dma = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h300;
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            mem_rdata = 32'hA000_0000 + 32'(i);
            k = i / 2;
            @(negedge clk);
            chk_cnt++;
            if ((i % 2) == 0) begin
                if (cpu_gnt !== !exp_dma[k] || dma_gnt !== exp_dma[k])
                    $display("FAIL b2b_gnt%0d got %b want %b", k, {cpu_gnt, dma_gnt}, {!exp_dma[k], exp_dma[k]});
                else pass_cnt++;
                if (i > 0) begin
                    chk_cnt++;
                    if ((exp_dma[k-1] ? dma_rvalid : cpu_rvalid) !== 1'b1 ||
                        (exp_dma[k-1] ? dma_rdata : cpu_rdata) !== 32'hA000_0000 + 32'(i - 1))
                        $display("FAIL b2b_rv%0d got cpu=%b/%h dma=%b/%h want rdata %h", k - 1,
                                 cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata, 32'hA000_0000 + 32'(i - 1));
                    else pass_cnt++;
                end
            end else begin
                if ({cpu_gnt, dma_gnt} !== 2'b00 || mem_req !== 1'b1 ||
                    mem_addr !== (exp_dma[k] ? 32'h300 : 32'h200))
                    $display("FAIL b2b_xfer%0d got gnt=%b req=%b addr=%h", k, {cpu_gnt, dma_gnt}, mem_req, mem_addr);
                else pass_cnt++;
            end
            next_cycle();
        end
        cpu_req = 1'b0; dma_req = 1'b0; mem_ready = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ((exp_dma[3] ? dma_rvalid : cpu_rvalid) !== 1'b1 ||
            (exp_dma[3] ? dma_rdata : cpu_rdata) !== 32'hA000_0007 || {cpu_gnt, dma_gnt} !== 2'b00)
            $display("FAIL b2b_last got cpu=%b/%h dma=%b/%h want rdata a0000007",
                     cpu_rvalid, cpu_rdata, dma_rvalid, dma_rdata);
        else pass_cnt++;
    endtask

    task automatic test_xfer_lockout();
        next_cycle();
        mem_ready = 1'b1; mem_rdata = 32'h5555_5555;
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if ({mem_req, busy, cpu_rvalid, dma_rvalid} !== 4'b0)
            $display("FAIL idle_ready got %b want 0000", {mem_req, busy, cpu_rvalid, dma_rvalid});
        else pass_cnt++;
        next_cycle();
        mem_ready = 1'b0;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 32'h80;
        @(negedge clk);
        chk_cnt++;
        if (dma_gnt !== 1'b1) $display("FAIL lock_dgnt got %b want 1", dma_gnt);
        else pass_cnt++;
        next_cycle();
        dma_req = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h900;
        @(negedge clk);
        chk_cnt++;
        if ({cpu_gnt, dma_gnt} !== 2'b00 || mem_addr !== 32'h80)
            $display("FAIL lock_xfer got gnt=%b addr=%h want 00 80", {cpu_gnt, dma_gnt}, mem_addr);
        else pass_cnt++;
        next_cycle();
        cpu_req = 1'b0; mem_ready = 1'b1; mem_rdata = 32'h77;
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h77 || cpu_gnt !== 1'b0)
            $display("FAIL lock_done got rv=%b rdata=%h cgnt=%b want 1 77 0", dma_rvalid, dma_rdata, cpu_gnt);
        else pass_cnt++;
        next_cycle();
        @(negedge clk);
        chk_cnt++;
        if ({mem_req, busy} !== 2'b00) $display("FAIL withdrawn got req/busy=%b want 00", {mem_req, busy});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        next_cycle();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h444; mem_ready = 1'b0;
        next_cycle();
        cpu_req = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk_cnt++;
        if ({mem_req, busy, cpu_gnt, cpu_rvalid} !== 4'b0 || cpu_rdata !== 32'h0)
            $display("FAIL rst_mid got req/busy/gnt/rv=%b rdata=%h want 0000 0",
                     {mem_req, busy, cpu_gnt, cpu_rvalid}, cpu_rdata);
        else pass_cnt++;
        mem_ready = 1'b1;
        next_cycle();
        reset = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h500; cpu_wdata = 32'h55;
        @(negedge clk);
        chk_cnt++;
        if (cpu_gnt !== 1'b1 || cpu_rvalid !== 1'b0)
            $display("FAIL rst_regnt got gnt=%b rv=%b want 1 0", cpu_gnt, cpu_rvalid);
        else pass_cnt++;
        next_cycle();
        cpu_req = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({mem_req, mem_we} !== 2'b11 || mem_addr !== 32'h500 || mem_wdata !== 32'h55 || cpu_rvalid !== 1'b0)
            $display("FAIL rst_mem got req/we=%b addr=%h wdata=%h rv=%b want 11 500 55 0",
                     {mem_req, mem_we}, mem_addr, mem_wdata, cpu_rvalid);
        else pass_cnt++;
        next_cycle();
        mem_ready = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h0)
            $display("FAIL rst_wr got rv=%b rdata=%h want 1 0", cpu_rvalid, cpu_rdata);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_dma_write();
        test_back_to_back();
        test_xfer_lockout();
        test_reset_mid();
        next_cycle();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
